// File: rtl/grid_io_bank_cfg.sv
`default_nettype none
// ============================================================================
// Module   : grid_io_bank_cfg
// Brief    : GPIO grid tile whose per-subtile mode bits live in a bank-style
//            config array written through one-hot word lines and bit lines.
// Revision : 1.0
// ============================================================================
module grid_io_bank_cfg #(
  parameter int NUM_SUBTILE = 8,
  parameter int BL_W        = 5,
  parameter int WL_W        = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  inout  wire  [NUM_SUBTILE-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_SUBTILE-1:0] outpad,
  output logic [NUM_SUBTILE-1:0] inpad,
  input  logic [BL_W-1:0]        bl,
  input  logic [WL_W-1:0]        wl,
  input  logic                   cfg_we,
  output logic [BL_W-1:0]        cfg_rd,
  output logic                   cfg_err
);

  localparam int NCFG  = 3 * NUM_SUBTILE;
  localparam int NCELL = BL_W * WL_W;

  if (NCELL < NCFG) begin : g_size_check
    $error("grid_io_bank_cfg: BL_W*WL_W too small for 3*NUM_SUBTILE config bits");
  end

  logic [NCFG-1:0]        cfg_q, cfg_d;
  logic [BL_W-1:0]        rd_q, rd_d;
  logic                   err_q, err_d;
  logic [NUM_SUBTILE-1:0] oq_q, s1_q, s2_q;
  logic [NCELL-1:0]       cells;
  logic                   wl_any, wl_onehot, wl_multi, wr_en;

  assign wl_any    = |wl;
  assign wl_onehot = wl_any && ((wl & (wl - WL_W'(1))) == '0);
  assign wl_multi  = wl_any && !wl_onehot;
  assign wr_en     = cfg_we && wl_onehot;
  assign err_d     = err_q || wl_multi;

  // Cells beyond the last real config bit exist only as zero readback.
  assign cells = NCELL'(cfg_q);

  for (genvar j = 0; j < NCFG; j++) begin : g_cell
    localparam int ROW = j / BL_W;
    localparam int COL = j % BL_W;
    assign cfg_d[j] = (wr_en && wl[ROW]) ? bl[COL] : cfg_q[j];
  end

  for (genvar c = 0; c < BL_W; c++) begin : g_rd_col
    logic [WL_W-1:0] col_bits;
    for (genvar r = 0; r < WL_W; r++) begin : g_rd_row
      assign col_bits[r] = cells[r*BL_W + c];
    end
    assign rd_d[c] = wl_onehot && (|(wl & col_bits));
  end

  for (genvar i = 0; i < NUM_SUBTILE; i++) begin : g_subtile
    logic oe, oreg, isync, drive;
    assign oe    = cfg_q[3*i];
    assign oreg  = cfg_q[3*i + 1];
    assign isync = cfg_q[3*i + 2];
    assign drive = oreg ? oq_q[i] : outpad[i];
    assign gfpga_pad_GPIO_PAD[i] = oe ? drive : 1'bz;
    assign inpad[i] = isync ? s2_q[i] : gfpga_pad_GPIO_PAD[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
      oq_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      cfg_q <= cfg_d;
      rd_q  <= rd_d;
      err_q <= err_d;
      oq_q  <= outpad;
      s1_q  <= gfpga_pad_GPIO_PAD;
      s2_q  <= s1_q;
    end
  end

  assign cfg_rd  = rd_q;
  assign cfg_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_io_bank_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_io_bank_cfg
// Brief    : Directed self-checking bench for grid_io_bank_cfg (8 subtiles, 5x5).
// Revision : 1.0
// ============================================================================
module tb_grid_io_bank_cfg;

  logic       clk;
  logic       reset;
  wire  [7:0] pad;
  logic [7:0] outpad;
  logic [7:0] inpad;
  logic [4:0] bl;
  logic [4:0] wl;
  logic       cfg_we;
  logic [4:0] cfg_rd;
  logic       cfg_err;
  logic [7:0] tb_en;
  logic [7:0] tb_val;

  int pass_cnt;
  int total_cnt;

  grid_io_bank_cfg #(.NUM_SUBTILE(8), .BL_W(5), .WL_W(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .gfpga_pad_GPIO_PAD (pad),
    .outpad             (outpad),
    .inpad              (inpad),
    .bl                 (bl),
    .wl                 (wl),
    .cfg_we             (cfg_we),
    .cfg_rd             (cfg_rd),
    .cfg_err            (cfg_err)
  );

  // Undriven pads settle low so high-Z is observable as 0 while outpad is 1.
  for (genvar g = 0; g < 8; g++) begin : g_pad_env
    pulldown (pad[g]);
    assign pad[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int row, input logic [4:0] bits);
    wl     = 5'(1 << row);
    bl     = bits;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    wl     = '0;
  endtask

  task automatic read_row(input int row, output logic [4:0] v);
    wl     = 5'(1 << row);
    cfg_we = 1'b0;
    tick();
    v  = cfg_rd;
    wl = '0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bl     = 5'($urandom);
    wl     = 5'($urandom);
    outpad = 8'($urandom);
    cfg_we = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (pad !== 8'h00) $display("FAIL reset_pad_z: got %h want 00", pad); else pass_cnt++;
    total_cnt++;
    if (cfg_rd !== 5'b0) $display("FAIL reset_cfg_rd: got %b want 00000", cfg_rd); else pass_cnt++;
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", cfg_err); else pass_cnt++;
    total_cnt++;
    if (inpad !== 8'h00) $display("FAIL reset_inpad: got %h want 00", inpad); else pass_cnt++;
    wl     = '0;
    bl     = '0;
    outpad = 8'hFF;
    reset  = 1'b0;
  endtask

  task automatic test_row_write();
    logic [4:0] v;
    wl = 5'b00001; bl = 5'b11111; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    total_cnt++;
    if (cfg_rd !== 5'b00000) $display("FAIL rd_same_cycle_prewrite: got %b want 00000", cfg_rd); else pass_cnt++;
    total_cnt++;
    if (pad !== 8'h03) $display("FAIL row0_pads: got %h want 03", pad); else pass_cnt++;
    tick();
    total_cnt++;
    if (cfg_rd !== 5'b11111) $display("FAIL row0_readback: got %b want 11111", cfg_rd); else pass_cnt++;
    total_cnt++;
    if (inpad[0] !== 1'b0) $display("FAIL row0_isync_lat1: got %b want 0", inpad[0]); else pass_cnt++;
    tick();
    total_cnt++;
    if (inpad !== 8'h03) $display("FAIL row0_inpad: got %h want 03", inpad); else pass_cnt++;
    wl = 5'b10000; bl = 5'b11111; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    total_cnt++;
    if (cfg_rd !== 5'b01111) $display("FAIL row4_readback: got %b want 01111", cfg_rd); else pass_cnt++;
    total_cnt++;
    if (pad !== 8'h83) $display("FAIL row4_pads: got %h want 83", pad); else pass_cnt++;
    read_row(1, v);
    total_cnt++;
    if (v !== 5'b00000) $display("FAIL row1_untouched: got %b want 00000", v); else pass_cnt++;
    cfg_write(0, 5'b00000);
    cfg_write(4, 5'b00000);
    outpad = 8'h00;
  endtask

  task automatic test_output_modes();
    cfg_write(1, 5'b00010);
    outpad[2] = 1'b1;
    #1;
    total_cnt++;
    if (pad !== 8'h04) $display("FAIL oe_comb_step: got %h want 04", pad); else pass_cnt++;
    outpad[2] = 1'b0;
    #1;
    total_cnt++;
    if (pad[2] !== 1'b0) $display("FAIL oe_comb_fall: got %b want 0", pad[2]); else pass_cnt++;
    cfg_write(1, 5'b00110);
    outpad[2] = 1'b1;
    #1;
    total_cnt++;
    if (pad[2] !== 1'b0) $display("FAIL oreg_before_edge: got %b want 0", pad[2]); else pass_cnt++;
    tick();
    total_cnt++;
    if (pad[2] !== 1'b1) $display("FAIL oreg_after_edge: got %b want 1", pad[2]); else pass_cnt++;
    outpad = 8'h00;
    cfg_write(1, 5'b00000);
  endtask

  task automatic test_input_sync();
    tb_en  = 8'h08;
    tb_val = 8'h00;
    cfg_write(2, 5'b00010);
    tick();
    tick();
    total_cnt++;
    if (inpad[3] !== 1'b0) $display("FAIL isync_settled_low: got %b want 0", inpad[3]); else pass_cnt++;
    tb_val[3] = 1'b1;
    #1;
    total_cnt++;
    if (inpad[3] !== 1'b0) $display("FAIL isync_lat0: got %b want 0", inpad[3]); else pass_cnt++;
    tick();
    total_cnt++;
    if (inpad[3] !== 1'b0) $display("FAIL isync_lat1: got %b want 0", inpad[3]); else pass_cnt++;
    tick();
    total_cnt++;
    if (inpad[3] !== 1'b1) $display("FAIL isync_lat2: got %b want 1", inpad[3]); else pass_cnt++;
    cfg_write(2, 5'b00000);
    tb_val[3] = 1'b0;
    #1;
    total_cnt++;
    if (inpad[3] !== 1'b0) $display("FAIL comb_in_low: got %b want 0", inpad[3]); else pass_cnt++;
    tb_val[3] = 1'b1;
    #1;
    total_cnt++;
    if (inpad[3] !== 1'b1) $display("FAIL comb_in_high: got %b want 1", inpad[3]); else pass_cnt++;
    tb_en  = 8'h00;
    tb_val = 8'h00;
  endtask

  task automatic test_bad_wl();
    logic [4:0] v;
    cfg_write(0, 5'b00101);
    cfg_write(1, 5'b01000);
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL err_before_bad: got %b want 0", cfg_err); else pass_cnt++;
    wl = 5'b00011; bl = 5'b11111; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    wl     = '0;
    total_cnt++;
    if (cfg_err !== 1'b1) $display("FAIL err_set: got %b want 1", cfg_err); else pass_cnt++;
    total_cnt++;
    if (cfg_rd !== 5'b00000) $display("FAIL multi_wl_rd_zero: got %b want 00000", cfg_rd); else pass_cnt++;
    read_row(0, v);
    total_cnt++;
    if (v !== 5'b00101) $display("FAIL bad_wl_row0_kept: got %b want 00101", v); else pass_cnt++;
    read_row(1, v);
    total_cnt++;
    if (v !== 5'b01000) $display("FAIL bad_wl_row1_kept: got %b want 01000", v); else pass_cnt++;
    cfg_write(2, 5'b11111);
    total_cnt++;
    if (cfg_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", cfg_err); else pass_cnt++;
    read_row(2, v);
    total_cnt++;
    if (v !== 5'b11111) $display("FAIL write_after_err: got %b want 11111", v); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [4:0] v;
    cfg_write(0, 5'b11011);
    cfg_write(1, 5'b10110);
    cfg_write(2, 5'b01101);
    cfg_write(3, 5'b11011);
    cfg_write(4, 5'b00110);
    outpad = 8'hFF;
    tick();
    tick();
    total_cnt++;
    if (pad !== 8'hFF) $display("FAIL all_drive_pads: got %h want ff", pad); else pass_cnt++;
    total_cnt++;
    if (inpad !== 8'hFF) $display("FAIL all_drive_inpad: got %h want ff", inpad); else pass_cnt++;
    #3;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (pad !== 8'h00) $display("FAIL async_reset_pad_z: got %h want 00", pad); else pass_cnt++;
    total_cnt++;
    if (cfg_err !== 1'b0) $display("FAIL async_reset_err: got %b want 0", cfg_err); else pass_cnt++;
    tick();
    reset  = 1'b0;
    outpad = 8'h00;
    for (int r = 0; r < 5; r++) begin
      read_row(r, v);
      total_cnt++;
      if (v !== 5'b00000) $display("FAIL post_reset_row%0d: got %b want 00000", r, v); else pass_cnt++;
    end
    wl     = 5'b10100;
    cfg_we = 1'b0;
    tick();
    wl = '0;
    total_cnt++;
    if (cfg_err !== 1'b1) $display("FAIL read_multi_wl_err: got %b want 1", cfg_err); else pass_cnt++;
    total_cnt++;
    if (cfg_rd !== 5'b00000) $display("FAIL read_multi_wl_rd: got %b want 00000", cfg_rd); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    outpad    = '0;
    bl        = '0;
    wl        = '0;
    cfg_we    = 1'b0;
    tb_en     = '0;
    tb_val    = '0;
    test_reset();
    test_row_write();
    test_output_modes();
    test_input_sync();
    test_bad_wl();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
